// File: rtl/ctrl_pkg.sv
// ctrl_pkg: mode select constants shared by the tick/pause front end
package ctrl_pkg;
  localparam int MODE_W = 2;
  typedef logic [MODE_W-1:0] mode_t;
  localparam mode_t MODE_0 = 2'd0;
  localparam mode_t MODE_1 = 2'd1;
  localparam mode_t MODE_2 = 2'd2;
  localparam mode_t MODE_3 = 2'd3;
endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: 2-flop synchronizer, stable-count debouncer and registered press detect
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press
);
  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [1:0] sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic level_q, level_d, prev_q, press_q, differ, done;
  always_comb begin
    differ = sync_q[1] ^ level_q;
    done = differ & (cnt_q == LAST);
    level_d = level_q ^ done;
    cnt_d = (differ & ~done) ? cnt_q + 1'b1 : '0;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      cnt_q <= '0;
      level_q <= 1'b0;
      prev_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_raw};
      cnt_q <= cnt_d;
      level_q <= level_d;
      prev_q <= level_q;
      press_q <= level_q & ~prev_q;
    end
  end
  assign level = level_q;
  assign press = press_q;
endmodule

// File: rtl/tick_pause_ctrl.sv
// tick_pause_ctrl: debounced pause/mode buttons, mode counter and pausable tick prescaler
module tick_pause_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV        = 25_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_pause,
  input  logic              btn_mode,
  output logic              tick,
  output logic              pause,
  output logic [MODE_W-1:0] mode,
  output logic              mode_change
);
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
  logic pause_press, mode_press, unused_pause_lvl, unused_mode_lvl;
  logic pause_q, pause_d, tick_q, tick_d, mc_q, run, at_end;
  mode_t mode_q, mode_d;
  logic [PW-1:0] presc_q, presc_d;
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause (
    .clk(clk), .reset(reset), .btn_raw(btn_pause), .level(unused_pause_lvl), .press(pause_press)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
    .clk(clk), .reset(reset), .btn_raw(btn_mode), .level(unused_mode_lvl), .press(mode_press)
  );
  // prescaler only advances when paused neither now nor after this edge, so no tick escapes a pause
  always_comb begin
    pause_d = mode_press ? 1'b0 : pause_q ^ pause_press;
    mode_d = mode_press ? ((mode_q == MODE_3) ? MODE_0 : mode_q + 1'b1) : mode_q;
    run = ~pause_q & ~pause_d & ~mode_press;
    at_end = presc_q == LAST;
    presc_d = mode_press ? '0 : run ? (at_end ? '0 : presc_q + 1'b1) : presc_q;
    tick_d = run & at_end;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pause_q <= 1'b0;
      mode_q <= MODE_0;
      mc_q <= 1'b0;
      presc_q <= '0;
      tick_q <= 1'b0;
    end else begin
      pause_q <= pause_d;
      mode_q <= mode_d;
      mc_q <= mode_press;
      presc_q <= presc_d;
      tick_q <= tick_d;
    end
  end
  assign tick = tick_q;
  assign pause = pause_q;
  assign mode = mode_q;
  assign mode_change = mc_q;
endmodule

// File: tb/tb_tick_pause_ctrl.sv
// tb_tick_pause_ctrl: directed checks of tick period, pause toggle, mode stepping and reset
module tb_tick_pause_ctrl;
  logic clk = 1'b0, reset = 1'b0, btn_pause = 1'b0, btn_mode = 1'b0;
  logic tick, pause, mode_change;
  logic [1:0] mode;
  int vecs = 0, errs = 0;

  tick_pause_ctrl #(.TICK_DIV(4), .DEBOUNCE_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .btn_pause(btn_pause), .btn_mode(btn_mode),
    .tick(tick), .pause(pause), .mode(mode), .mode_change(mode_change)
  );

  always #10 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    btn_pause = 1'b0;
    btn_mode = 1'b0;
    step(2);
    reset = 1'b1;
  endtask

  task automatic test_reset;
    logic e;
    reset = 1'b0;
    step(2);
    vecs += 4;
    if (tick !== 1'b0) begin errs++; $display("FAIL rst_tick got=%0b exp=0", tick); end
    if (pause !== 1'b0) begin errs++; $display("FAIL rst_pause got=%0b exp=0", pause); end
    if (mode !== 2'd0) begin errs++; $display("FAIL rst_mode got=%0d exp=0", mode); end
    if (mode_change !== 1'b0) begin errs++; $display("FAIL rst_mc got=%0b exp=0", mode_change); end
    reset = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      e = (k % 4 == 0);
      vecs++;
      if (tick !== e) begin errs++; $display("FAIL free_tick k=%0d got=%0b exp=%0b", k, tick, e); end
      vecs++;
      if (pause !== 1'b0 || mode !== 2'd0) begin errs++; $display("FAIL free_state k=%0d got=%0b/%0d exp=0/0", k, pause, mode); end
    end
  endtask

  task automatic test_pause;
    logic ep, et;
    do_reset;
    btn_pause = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step(1);
      if (k == 10 || k == 26) btn_pause = 1'b0;
      if (k == 16) btn_pause = 1'b1;
      ep = (k >= 7 && k < 23);
      et = (k == 4 || k == 25 || k == 29);
      vecs++;
      if (pause !== ep) begin errs++; $display("FAIL pause_lvl k=%0d got=%0b exp=%0b", k, pause, ep); end
      vecs++;
      if (tick !== et) begin errs++; $display("FAIL pause_tick k=%0d got=%0b exp=%0b", k, tick, et); end
    end
  endtask

  task automatic test_bounce;
    logic e;
    do_reset;
    btn_mode = 1'b1;
    step(1);
    btn_mode = 1'b0;
    step(4);
    btn_mode = 1'b1;
    step(2);
    btn_mode = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      vecs++;
      if (mode_change !== 1'b0 || mode !== 2'd0) begin errs++; $display("FAIL bounce k=%0d got=%0b/%0d exp=0/0", k, mode_change, mode); end
    end
    btn_mode = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      if (k == 3) btn_mode = 1'b0;
      e = (k == 7);
      vecs++;
      if (mode_change !== e) begin errs++; $display("FAIL min_press_mc k=%0d got=%0b exp=%0b", k, mode_change, e); end
      vecs++;
      if (mode !== ((k >= 7) ? 2'd1 : 2'd0)) begin errs++; $display("FAIL min_press_mode k=%0d got=%0d", k, mode); end
    end
  endtask

  task automatic test_mode;
    logic ep, et, em;
    logic [1:0] pm, xm;
    do_reset;
    btn_pause = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      if (k == 4) btn_pause = 1'b0;
      ep = (k >= 7);
      vecs++;
      if (pause !== ep) begin errs++; $display("FAIL pre_pause k=%0d got=%0b exp=%0b", k, pause, ep); end
    end
    pm = 2'd0;
    for (int i = 0; i < 4; i++) begin
      xm = pm + 2'd1;
      btn_mode = 1'b1;
      for (int k = 1; k <= 14; k++) begin
        step(1);
        if (k == 4) btn_mode = 1'b0;
        em = (k == 7);
        ep = (i == 0 && k < 7);
        et = (k == 11) || (i > 0 && (k == 1 || k == 5));
        vecs++;
        if (mode !== ((k >= 7) ? xm : pm)) begin errs++; $display("FAIL mode_val i=%0d k=%0d got=%0d", i, k, mode); end
        vecs++;
        if (mode_change !== em) begin errs++; $display("FAIL mode_mc i=%0d k=%0d got=%0b exp=%0b", i, k, mode_change, em); end
        vecs++;
        if (pause !== ep) begin errs++; $display("FAIL mode_pause i=%0d k=%0d got=%0b exp=%0b", i, k, pause, ep); end
        vecs++;
        if (tick !== et) begin errs++; $display("FAIL mode_tick i=%0d k=%0d got=%0b exp=%0b", i, k, tick, et); end
      end
      pm = xm;
    end
  endtask

  task automatic test_both;
    logic em;
    do_reset;
    btn_pause = 1'b1;
    btn_mode = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      if (k == 4) begin btn_pause = 1'b0; btn_mode = 1'b0; end
      em = (k == 7);
      vecs++;
      if (mode !== ((k >= 7) ? 2'd1 : 2'd0)) begin errs++; $display("FAIL both_mode k=%0d got=%0d", k, mode); end
      vecs++;
      if (pause !== 1'b0) begin errs++; $display("FAIL both_pause k=%0d got=%0b exp=0", k, pause); end
      vecs++;
      if (mode_change !== em) begin errs++; $display("FAIL both_mc k=%0d got=%0b exp=%0b", k, mode_change, em); end
    end
  endtask

  task automatic test_reset_mid;
    logic e;
    do_reset;
    step(4);
    vecs++;
    if (tick !== 1'b1) begin errs++; $display("FAIL mid_pre_tick got=%0b exp=1", tick); end
    #4 reset = 1'b0;
    #1;
    vecs++;
    if (tick !== 1'b0) begin errs++; $display("FAIL mid_async_tick got=%0b exp=0", tick); end
    step(1);
    reset = 1'b1;
    btn_mode = 1'b1;
    step(4);
    btn_mode = 1'b0;
    step(10);
    btn_pause = 1'b1;
    step(4);
    btn_pause = 1'b0;
    step(6);
    vecs++;
    if (mode !== 2'd1 || pause !== 1'b1) begin errs++; $display("FAIL mid_pre_state got=%0d/%0b exp=1/1", mode, pause); end
    btn_mode = 1'b1;
    step(3);
    #5 reset = 1'b0;
    #1;
    vecs++;
    if (mode !== 2'd0 || pause !== 1'b0 || tick !== 1'b0 || mode_change !== 1'b0)
      begin errs++; $display("FAIL mid_async_clear got=%0d/%0b/%0b/%0b exp=0/0/0/0", mode, pause, tick, mode_change); end
    btn_mode = 1'b0;
    step(1);
    reset = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      e = (k % 4 == 0);
      vecs++;
      if (tick !== e) begin errs++; $display("FAIL post_rst_tick k=%0d got=%0b exp=%0b", k, tick, e); end
      vecs++;
      if (mode !== 2'd0 || mode_change !== 1'b0) begin errs++; $display("FAIL post_rst_mode k=%0d got=%0d/%0b exp=0/0", k, mode, mode_change); end
    end
  endtask

  initial begin
    test_reset;
    test_pause;
    test_bounce;
    test_mode;
    test_both;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/tick_pause_ctrl.md
# tick_pause_ctrl

Front-end control stage that generates the `tick` strobe and the `pause` level consumed by the per-mode LED processors, and the 2-bit `mode` select that steers among the four processors. It conditions two raw push-buttons (pause, mode) through synchronizers and debouncers. It divides the system clock into a one-cycle `tick` strobe that freezes while paused.

## Interface
- `TICK_DIV`, 25_000_000: clock cycles per `tick` period; legal range ≥1.
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable cycles required to accept a button level change; legal range ≥1.
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset; single clock domain.
- `btn_pause`  in  1  raw pause button, active-high, asynchronous to `clk`, bouncy.
- `btn_mode`  in  1  raw mode button, active-high, asynchronous, bouncy.
- `tick`  out  1  one-cycle strobe every `TICK_DIV` cycles while not paused.
- `pause`  out  1  pause level, toggled by each accepted pause press.
- `mode`  out  2  current mode 0..3.
- `mode_change`  out  1  one-cycle strobe on the cycle `mode` takes a new value.

## Operation
- Reset values (while `reset`=0): `tick`=0, `pause`=0, `mode`=0, `mode_change`=0, prescaler=0, debounced levels=0, debounce counters=0, synchronizers=0.
- Each button: 2-flop synchronizer -> debouncer. The debouncer holds a stable level and a counter.
  - If the synced input equals the stable level, the counter is cleared.
  - Otherwise the counter increments. When it reaches `DEBOUNCE_CYCLES`, the stable level flips and the counter clears.
- Press event = stable level 0->1 (registered, one cycle). Release events are ignored.
- Pause press: `pause` <= ~`pause`.
- Mode press: `mode` <= `mode`+1 mod 4 (3 wraps to 0). Same edge: `mode_change`=1 next cycle, `pause` <= 0, prescaler <= 0.
- Simultaneous pause press and mode press: mode press wins; `pause`=0, `mode` increments.
- Prescaler counts 0..`TICK_DIV`-1 while `pause`=0. It holds its value while `pause`=1, so resume continues mid-period.
- `tick` is registered: it is 1 for the cycle after the prescaler equals `TICK_DIV`-1 (prescaler wraps to 0 on that edge). `tick` is never 1 while `pause`=1, including the cycle after pause asserts.
- `TICK_DIV`=1: `tick` is 1 every cycle while unpaused.
- Counter widths: $clog2 of the parameter, minimum 1 bit. No overflow is possible because counters clear at terminal value.

## Timing
- Raw button level change held stable: the debounced level flips on edge 2+`DEBOUNCE_CYCLES` after the first edge that samples the new level. The press event is registered on the next edge. `pause`/`mode` update one edge after that.
- Bounce shorter than `DEBOUNCE_CYCLES` produces no event. A held button produces exactly one event.
- First `tick` after reset release: the cycle after `TICK_DIV` rising edges. Period is exactly `TICK_DIV` cycles while unpaused.
- Reset assertion mid-debounce or mid-period: all state returns to reset values immediately (asynchronous). Release is synchronous to `clk` from the consumer's view.
- `mode_change` and the prescaler clear occur on the same edge. The next `tick` arrives `TICK_DIV` cycles later.

## Structure
- Shared package `ctrl_pkg`:
  - mode constants `MODE_0`..`MODE_3` (2-bit);
  - `MODE_W`=2.
- One sub-module, `button_debouncer` (param `DEBOUNCE_CYCLES`; ports `clk`, `reset`, `btn_raw`, `level`, `press`). It contains the synchronizer, counter and edge detect, and is instantiated twice.
- Top holds the pause toggle, mode counter, prescaler and output registers.

## Test plan
Parameters `TICK_DIV`=4, `DEBOUNCE_CYCLES`=3, 20 ns clock.
1. Reset release, no buttons -> `tick` pulses one cycle every 4 cycles, first at cycle 5. `pause`=0, `mode`=0.
2. `btn_pause` high for 10 cycles -> `pause`=1 seven edges after the first sampled high. `tick` stays 0 with the prescaler frozen. A second press restores `pause`=0, and `tick` resumes with the remaining period.
3. `btn_mode` pulsed 1 and 2 cycles only (bounce) -> no `mode_change`, `mode`=0.
4. Four clean mode presses -> `mode` 1,2,3,0. Each is accompanied by a one-cycle `mode_change`, and a press while paused forces `pause`=0.
5. Both buttons pressed on the same cycle while `pause`=0 -> `mode`=1, `pause`=0.
6. `reset` asserted mid-period and mid-debounce -> all outputs 0 immediately. After release the first `tick` comes at cycle 5 and the partial press is discarded.
